ddr3_port_arbiter: RTL and testbench
====================================

Name: ddr3_port_arbiter

Overview:
Two-requester arbiter sharing the single DDR3 controller Avalon-MM local port. Requester 0 is the CPU (xenowing) memory port; requester 1 is a DMA/display engine. Single-beat transactions only. Read data is routed back to the issuing requester in order through an in-flight ID FIFO.

Parameters:
ADDR_WIDTH, 24, Avalon word address width, shared by requesters and controller.
DATA_WIDTH, 64, requester data width; must be ≤ CTRL_DATA_WIDTH.
CTRL_DATA_WIDTH, 96, controller avl_rdata/avl_wdata width; avl_be is CTRL_DATA_WIDTH/8.
INFLIGHT_DEPTH, 16, maximum outstanding reads; power of 2, ≥2.

Ports:
clk  in  1  system clock (controller afi_clk)
reset_n  in  1  asynchronous active-low reset
m0_ready, m1_ready  out  1 each  request accepted this cycle when high with req
m0_addr, m1_addr  in  ADDR_WIDTH each  word address
m0_read_req, m1_read_req  in  1 each  read request
m0_write_req, m1_write_req  in  1 each  write request
m0_wdata, m1_wdata  in  DATA_WIDTH each  write data
m0_be, m1_be  in  DATA_WIDTH/8 each  byte enables
m0_rdata_valid, m1_rdata_valid  out  1 each  read data valid
m0_rdata, m1_rdata  out  DATA_WIDTH each  read data (shared copy of avl_rdata low bits)
avl_ready  in  1  controller ready
avl_burstbegin  out  1  high with every issued request
avl_addr  out  ADDR_WIDTH  selected address
avl_read_req, avl_write_req  out  1 each  selected request
avl_wdata  out  CTRL_DATA_WIDTH  selected wdata, upper bits zero
avl_be  out  CTRL_DATA_WIDTH/8  selected be, upper bits zero
avl_size  out  7  constant 1
avl_rdata_valid  in  1  controller read data valid
avl_rdata  in  CTRL_DATA_WIDTH  controller read data

Behaviour:
- State: last_grant (1 bit, reset 1 so m0 wins first), ID FIFO (INFLIGHT_DEPTH x 1 bit, count 0..INFLIGHT_DEPTH, reset empty).
- Requester i is eligible when (read_req_i or write_req_i) and not (read_req_i and fifo_full). read_req and write_req both high from one requester is illegal (assertion); treat as read.
- Selection (combinational): one eligible → it; both eligible → requester != last_grant; none → no request.
- avl_read_req/avl_write_req/avl_burstbegin/addr/wdata/be driven from selected requester, zero-latency passthrough; all zero when none selected or reset_n low.
- mi_ready = selected==i && avl_ready; unselected requester holds its request (Avalon hold rule).
- On issue (selected && avl_ready): last_grant <= selected; if read, push selected ID.
- Ineligible requester never blocks the other: FIFO full stalls reads only; writes still issue.
- avl_rdata_valid: pop FIFO head; m<head>_rdata_valid = 1 same cycle, other 0. mi_rdata = avl_rdata[DATA_WIDTH-1:0] always.
- Simultaneous push and pop: count unchanged, order preserved; pop when full permits read push in same cycle? No—eligibility uses registered full, so no push when full.
- avl_rdata_valid with FIFO empty: ignored, both rdata_valid 0, assertion fires.
- Reset mid-operation: FIFO cleared, outstanding read returns discarded; controller is held in reset by same source (local_init_done), so none arrive.
- All ready/valid outputs 0 while reset_n low.

Optional Feature:
DDR3_ARB_PERF_EN: when defined, adds outputs perf_m0_grants, perf_m1_grants, perf_stall_cycles (32 bits each, reset 0, saturating at 0xFFFFFFFF). Grants increment on each issue per requester; stall increments each cycle any request is pending but no issue occurs. When undefined, ports and counters absent; behaviour otherwise identical.

Test Plan:
- m0 read at 0x000010 alone, avl_ready=1 → avl_read_req=1, addr 0x000010, m0_ready=1; returned avl_rdata 0x..DEADBEEF → m0_rdata_valid=1, m1_rdata_valid=0.
- Both requesters write continuously, avl_ready=1 → issues alternate m0,m1,m0,m1 starting with m0 after reset.
- m1 issues 3 reads, then m0 2 reads interleaved; controller returns 5 in order → valids route m1,m1,m1,m0,m0 (matching issue order).
- Fill FIFO with 16 reads, no returns → 17th read blocked (ready 0), m1 write still issues; one return frees slot, read issues next cycle.
- avl_ready=0 for 5 cycles with both requesting → no ready, requests held, no FIFO push; on avl_ready=1 correct round-robin winner issues once.
- Assert reset_n low with 4 reads outstanding → FIFO count 0, outputs 0; after release first grant goes to m0.

Source files
------------

// File: rtl/ddr3_port_arbiter.sv
// Two-port round-robin arbiter in front of a DDR3 Avalon-MM local port, with in-order read return routing.
// Optional DDR3_ARB_PERF_EN adds saturating grant/stall performance counters.
module ddr3_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 24,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_DATA_WIDTH = 96,
  parameter int unsigned INFLIGHT_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         m0_ready,
  input  logic [ADDR_WIDTH-1:0]        m0_addr,
  input  logic                         m0_read_req,
  input  logic                         m0_write_req,
  input  logic [DATA_WIDTH-1:0]        m0_wdata,
  input  logic [DATA_WIDTH/8-1:0]      m0_be,
  output logic                         m0_rdata_valid,
  output logic [DATA_WIDTH-1:0]        m0_rdata,
  output logic                         m1_ready,
  input  logic [ADDR_WIDTH-1:0]        m1_addr,
  input  logic                         m1_read_req,
  input  logic                         m1_write_req,
  input  logic [DATA_WIDTH-1:0]        m1_wdata,
  input  logic [DATA_WIDTH/8-1:0]      m1_be,
  output logic                         m1_rdata_valid,
  output logic [DATA_WIDTH-1:0]        m1_rdata,
  input  logic                         avl_ready,
  output logic                         avl_burstbegin,
  output logic [ADDR_WIDTH-1:0]        avl_addr,
  output logic                         avl_read_req,
  output logic                         avl_write_req,
  output logic [CTRL_DATA_WIDTH-1:0]   avl_wdata,
  output logic [CTRL_DATA_WIDTH/8-1:0] avl_be,
  output logic [6:0]                   avl_size,
  input  logic                         avl_rdata_valid,
  input  logic [CTRL_DATA_WIDTH-1:0]   avl_rdata
`ifdef DDR3_ARB_PERF_EN
  ,
  output logic [31:0]                  perf_m0_grants,
  output logic [31:0]                  perf_m1_grants,
  output logic [31:0]                  perf_stall_cycles
`endif
);

  localparam int unsigned PTR_WIDTH     = $clog2(INFLIGHT_DEPTH);
  localparam int unsigned CNT_WIDTH     = $clog2(INFLIGHT_DEPTH + 1);
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8;
  localparam int unsigned CTRL_BE_WIDTH = CTRL_DATA_WIDTH / 8;

  logic                      last_grant;
  logic [INFLIGHT_DEPTH-1:0] id_fifo;
  logic [PTR_WIDTH-1:0]      wr_ptr;
  logic [PTR_WIDTH-1:0]      rd_ptr;
  logic [CNT_WIDTH-1:0]      count;

  logic fifo_full, fifo_empty;
  logic elig0, elig1, sel_valid, sel_id, sel_read;
  logic issue, push, pop, head_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_WIDTH-1:0]   sel_be;
  logic                  unused_rdata_hi;

  assign unused_rdata_hi = ^avl_rdata[CTRL_DATA_WIDTH-1:DATA_WIDTH];

  // Selection and zero-latency passthrough to the controller
  always_comb begin
    fifo_full  = (count == CNT_WIDTH'(INFLIGHT_DEPTH));
    fifo_empty = (count == '0);
    head_id    = id_fifo[rd_ptr];
    elig0      = (m0_read_req | m0_write_req) & ~(m0_read_req & fifo_full);
    elig1      = (m1_read_req | m1_write_req) & ~(m1_read_req & fifo_full);
    sel_valid  = reset_n & (elig0 | elig1);
    sel_id     = (elig0 & elig1) ? ~last_grant : elig1;
    sel_read   = sel_id ? m1_read_req : m0_read_req;
    sel_addr   = sel_id ? m1_addr  : m0_addr;
    sel_wdata  = sel_id ? m1_wdata : m0_wdata;
    sel_be     = sel_id ? m1_be    : m0_be;
    issue      = sel_valid & avl_ready;
    push       = issue & sel_read;
    pop        = reset_n & avl_rdata_valid & ~fifo_empty;

    avl_read_req   = sel_valid & sel_read;
    avl_write_req  = sel_valid & ~sel_read;
    avl_burstbegin = sel_valid;
    avl_addr       = sel_valid ? sel_addr : '0;
    avl_wdata      = sel_valid ? CTRL_DATA_WIDTH'(sel_wdata) : '0;
    avl_be         = sel_valid ? CTRL_BE_WIDTH'(sel_be) : '0;
    avl_size       = 7'd1;
    m0_ready       = issue & ~sel_id;
    m1_ready       = issue & sel_id;
    m0_rdata_valid = pop & ~head_id;
    m1_rdata_valid = pop & head_id;
    m0_rdata       = avl_rdata[DATA_WIDTH-1:0];
    m1_rdata       = avl_rdata[DATA_WIDTH-1:0];
  end

  // Grant history and in-flight read ID FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      id_fifo    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (issue) last_grant <= sel_id;
      if (push) begin
        id_fifo[wr_ptr] <= sel_id;
        wr_ptr          <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DDR3_ARB_PERF_EN
  logic any_pending;
  assign any_pending = m0_read_req | m0_write_req | m1_read_req | m1_write_req;

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_m0_grants    <= '0;
      perf_m1_grants    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (issue && !sel_id && perf_m0_grants != '1) perf_m0_grants <= perf_m0_grants + 32'd1;
      if (issue && sel_id && perf_m1_grants != '1) perf_m1_grants <= perf_m1_grants + 32'd1;
      if (any_pending && !issue && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  a_m0_dual_req: assert property (@(posedge clk) disable iff (!reset_n)
    !(m0_read_req && m0_write_req));
  a_m1_dual_req: assert property (@(posedge clk) disable iff (!reset_n)
    !(m1_read_req && m1_write_req));
  a_rdata_unexpected: assert property (@(posedge clk) disable iff (!reset_n)
    !(avl_rdata_valid && fifo_empty));

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: vector table plus hand-written stall, FIFO-full and reset sequences.
module tb_ddr3_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_ready, m1_ready;
  logic [23:0] m0_addr, m1_addr;
  logic        m0_read_req, m0_write_req, m1_read_req, m1_write_req;
  logic [63:0] m0_wdata, m1_wdata;
  logic [7:0]  m0_be, m1_be;
  logic        m0_rdata_valid, m1_rdata_valid;
  logic [63:0] m0_rdata, m1_rdata;
  logic        avl_ready, avl_burstbegin, avl_read_req, avl_write_req;
  logic [23:0] avl_addr;
  logic [95:0] avl_wdata;
  logic [11:0] avl_be;
  logic [6:0]  avl_size;
  logic        avl_rdata_valid;
  logic [95:0] avl_rdata;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] W0  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W1  = 64'h5555_6666_7777_8888;
  localparam logic [7:0]  BE0 = 8'h0F;
  localparam logic [7:0]  BE1 = 8'hF0;

  ddr3_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_read_req(m0_read_req),
    .m0_write_req(m0_write_req), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_rdata_valid(m0_rdata_valid), .m0_rdata(m0_rdata),
    .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_read_req(m1_read_req),
    .m1_write_req(m1_write_req), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_rdata_valid(m1_rdata_valid), .m1_rdata(m1_rdata),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_size(avl_size),
    .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, w0;
    logic [23:0] a0;
    logic        r1, w1;
    logic [23:0] a1;
    logic        ardy, rv;
    logic [95:0] rd;
    logic        e_rdy0, e_rdy1, e_ard, e_awr;
    logic [1:0]  e_sel;
    logic        e_rv0, e_rv1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r0, w0, input logic [23:0] a0,
                              input logic r1, w1, input logic [23:0] a1,
                              input logic ardy, rv, input logic [95:0] rd,
                              input logic e_rdy0, e_rdy1, e_ard, e_awr,
                              input logic [1:0] e_sel, input logic e_rv0, e_rv1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.ardy = ardy; v.rv = rv; v.rd = rd;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_ard = e_ard; v.e_awr = e_awr;
    v.e_sel = e_sel; v.e_rv0 = e_rv0; v.e_rv1 = e_rv1;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [23:0] a0,
                       input logic r1, w1, input logic [23:0] a1,
                       input logic ardy, rv, input logic [95:0] rd);
    m0_read_req = r0; m0_write_req = w0; m0_addr = a0;
    m1_read_req = r1; m1_write_req = w1; m1_addr = a1;
    avl_ready = ardy; avl_rdata_valid = rv; avl_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 24'h0, 0, 0, 24'h0, 1, 0, 96'h0);
  endtask

  initial begin
    logic [95:0] rd;
    logic [95:0] exp_wd;
    logic [95:0] exp_be;
    logic [23:0] exp_addr;

    m0_wdata = W0; m1_wdata = W1; m0_be = BE0; m1_be = BE1;
    idle();
    reset_n = 1'b0;
    #4;
    chk1("reset_m0_ready", m0_ready, 1'b0);
    chk1("reset_m1_ready", m1_ready, 1'b0);
    chk1("reset_avl_burstbegin", avl_burstbegin, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // r0 w0 a0 r1 w1 a1 ardy rv rd | rdy0 rdy1 ard awr sel rv0 rv1
    vecs.push_back(mk(0,0,24'h0,  0,0,24'h0,  1,0,96'h0,                          0,0,0,0,2'd0,0,0));
    vecs.push_back(mk(0,1,24'h100,0,1,24'h200,1,0,96'h0,                          1,0,0,1,2'd1,0,0));
    vecs.push_back(mk(0,1,24'h100,0,1,24'h200,1,0,96'h0,                          0,1,0,1,2'd2,0,0));
    vecs.push_back(mk(0,1,24'h100,0,1,24'h200,1,0,96'h0,                          1,0,0,1,2'd1,0,0));
    vecs.push_back(mk(0,1,24'h100,0,1,24'h200,1,0,96'h0,                          0,1,0,1,2'd2,0,0));
    vecs.push_back(mk(1,0,24'h010,0,0,24'h0,  1,0,96'h0,                          1,0,1,0,2'd1,0,0));
    vecs.push_back(mk(0,0,24'h0,  0,0,24'h0,  1,1,96'h0123_4567_89AB_CDEF_DEAD_BEEF,0,0,0,0,2'd0,1,0));
    vecs.push_back(mk(0,0,24'h0,  1,0,24'h300,1,0,96'h0,                          0,1,1,0,2'd2,0,0));
    vecs.push_back(mk(0,0,24'h0,  1,0,24'h301,1,0,96'h0,                          0,1,1,0,2'd2,0,0));
    vecs.push_back(mk(0,0,24'h0,  1,0,24'h302,1,0,96'h0,                          0,1,1,0,2'd2,0,0));
    vecs.push_back(mk(1,0,24'h020,0,0,24'h0,  1,1,96'hA0A0_0000_0000_0000_0000_00A1,1,0,1,0,2'd1,0,1));
    vecs.push_back(mk(1,0,24'h021,0,0,24'h0,  1,1,96'hB0B0_0000_0000_0000_0000_00B2,1,0,1,0,2'd1,0,1));
    vecs.push_back(mk(0,0,24'h0,  0,0,24'h0,  1,1,96'h0000_0000_0000_0000_0000_00C3,0,0,0,0,2'd0,0,1));
    vecs.push_back(mk(0,0,24'h0,  0,0,24'h0,  1,1,96'h0000_0000_0000_0000_0000_00D4,0,0,0,0,2'd0,1,0));
    vecs.push_back(mk(0,0,24'h0,  0,0,24'h0,  1,1,96'h0000_0000_0000_0000_0000_00E5,0,0,0,0,2'd0,1,0));
    vecs.push_back(mk(0,1,24'h110,0,1,24'h210,1,0,96'h0,                          0,1,0,1,2'd2,0,0));
    vecs.push_back(mk(0,1,24'h111,1,0,24'h211,1,0,96'h0,                          1,0,0,1,2'd1,0,0));
    vecs.push_back(mk(0,0,24'h0,  1,0,24'h211,1,0,96'h0,                          0,1,1,0,2'd2,0,0));
    vecs.push_back(mk(0,0,24'h0,  0,0,24'h0,  1,1,96'h0000_0000_0000_0000_0000_00F6,0,0,0,0,2'd0,0,1));

    foreach (vecs[i]) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].r1, vecs[i].w1, vecs[i].a1,
            vecs[i].ardy, vecs[i].rv, vecs[i].rd);
      #4;
      rd       = vecs[i].rd;
      exp_addr = (vecs[i].e_sel == 2'd1) ? vecs[i].a0 : (vecs[i].e_sel == 2'd2) ? vecs[i].a1 : 24'h0;
      exp_wd   = (vecs[i].e_sel == 2'd1) ? 96'(W0) : (vecs[i].e_sel == 2'd2) ? 96'(W1) : 96'h0;
      exp_be   = (vecs[i].e_sel == 2'd1) ? 96'(BE0) : (vecs[i].e_sel == 2'd2) ? 96'(BE1) : 96'h0;
      chk1($sformatf("v%0d_m0_ready", i), m0_ready, vecs[i].e_rdy0);
      chk1($sformatf("v%0d_m1_ready", i), m1_ready, vecs[i].e_rdy1);
      chk1($sformatf("v%0d_avl_read_req", i), avl_read_req, vecs[i].e_ard);
      chk1($sformatf("v%0d_avl_write_req", i), avl_write_req, vecs[i].e_awr);
      chk1($sformatf("v%0d_avl_burstbegin", i), avl_burstbegin, vecs[i].e_ard | vecs[i].e_awr);
      chk1($sformatf("v%0d_m0_rdata_valid", i), m0_rdata_valid, vecs[i].e_rv0);
      chk1($sformatf("v%0d_m1_rdata_valid", i), m1_rdata_valid, vecs[i].e_rv1);
      chkw($sformatf("v%0d_avl_addr", i), 96'(avl_addr), 96'(exp_addr));
      chkw($sformatf("v%0d_avl_wdata", i), avl_wdata, exp_wd);
      chkw($sformatf("v%0d_avl_be", i), 96'(avl_be), exp_be);
      chkw($sformatf("v%0d_m0_rdata", i), 96'(m0_rdata), 96'(rd[63:0]));
      chkw($sformatf("v%0d_m1_rdata", i), 96'(m1_rdata), 96'(rd[63:0]));
      chkw($sformatf("v%0d_avl_size", i), 96'(avl_size), 96'd1);
      tick();
    end

    // Controller back-pressure: m1 was granted last, so m0 must win once ready returns
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 24'h400, 1, 0, 24'h500, 0, 0, 96'h0);
      #4;
      chk1($sformatf("stall%0d_m0_ready", c), m0_ready, 1'b0);
      chk1($sformatf("stall%0d_m1_ready", c), m1_ready, 1'b0);
      chk1($sformatf("stall%0d_avl_read_req", c), avl_read_req, 1'b1);
      chkw($sformatf("stall%0d_avl_addr", c), 96'(avl_addr), 96'h400);
      tick();
    end
    drive(1, 0, 24'h400, 1, 0, 24'h500, 1, 0, 96'h0);
    #4;
    chk1("stall_release_m0_ready", m0_ready, 1'b1);
    chk1("stall_release_m1_ready", m1_ready, 1'b0);
    tick();
    drive(0, 0, 24'h0, 1, 0, 24'h500, 1, 0, 96'h0);
    #4;
    chk1("stall_m1_after_ready", m1_ready, 1'b1);
    tick();
    drive(0, 0, 24'h0, 0, 0, 24'h0, 1, 1, 96'h11);
    #4;
    chk1("stall_ret0_m0_valid", m0_rdata_valid, 1'b1);
    chk1("stall_ret0_m1_valid", m1_rdata_valid, 1'b0);
    tick();
    drive(0, 0, 24'h0, 0, 0, 24'h0, 1, 1, 96'h22);
    #4;
    chk1("stall_ret1_m1_valid", m1_rdata_valid, 1'b1);
    chk1("stall_ret1_m0_valid", m0_rdata_valid, 1'b0);
    tick();

    // Fill the ID FIFO; a full FIFO blocks reads only
    for (int c = 0; c < 16; c++) begin
      drive(1, 0, 24'(c), 0, 0, 24'h0, 1, 0, 96'h0);
      #4;
      chk1($sformatf("fill%0d_m0_ready", c), m0_ready, 1'b1);
      tick();
    end
    drive(1, 0, 24'h7, 0, 1, 24'h600, 1, 0, 96'h0);
    #4;
    chk1("full_m0_ready", m0_ready, 1'b0);
    chk1("full_m1_write_ready", m1_ready, 1'b1);
    chk1("full_avl_write_req", avl_write_req, 1'b1);
    chk1("full_avl_read_req", avl_read_req, 1'b0);
    tick();
    drive(1, 0, 24'h7, 0, 0, 24'h0, 1, 1, 96'h33);
    #4;
    chk1("full_pop_m0_ready", m0_ready, 1'b0);
    chk1("full_pop_m0_valid", m0_rdata_valid, 1'b1);
    tick();
    drive(1, 0, 24'h7, 0, 0, 24'h0, 1, 0, 96'h0);
    #4;
    chk1("freed_m0_ready", m0_ready, 1'b1);
    tick();
    for (int c = 0; c < 16; c++) begin
      drive(0, 0, 24'h0, 0, 0, 24'h0, 1, 1, 96'(c));
      #4;
      chk1($sformatf("drain%0d_m0_valid", c), m0_rdata_valid, 1'b1);
      tick();
    end

    // Reset with reads outstanding
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 24'h0, 1, 0, 24'(c), 1, 0, 96'h0);
      #4;
      chk1($sformatf("pre_rst%0d_m1_ready", c), m1_ready, 1'b1);
      tick();
    end
    drive(1, 0, 24'h1, 1, 0, 24'h2, 1, 1, 96'h44);
    #2;
    reset_n = 1'b0;
    #2;
    chk1("in_rst_m0_ready", m0_ready, 1'b0);
    chk1("in_rst_m1_ready", m1_ready, 1'b0);
    chk1("in_rst_avl_read_req", avl_read_req, 1'b0);
    chk1("in_rst_avl_burstbegin", avl_burstbegin, 1'b0);
    chk1("in_rst_m0_valid", m0_rdata_valid, 1'b0);
    chk1("in_rst_m1_valid", m1_rdata_valid, 1'b0);
    tick();
    drive(0, 1, 24'h700, 0, 1, 24'h800, 1, 0, 96'h0);
    reset_n = 1'b1;
    #4;
    chk1("post_rst_m0_ready", m0_ready, 1'b1);
    chk1("post_rst_m1_ready", m1_ready, 1'b0);
    tick();
    for (int c = 0; c < 17; c++) begin
      drive(1, 0, 24'(c), 0, 0, 24'h0, 1, 0, 96'h0);
      #4;
      chk1($sformatf("post_rst_fill%0d_m0_ready", c), m0_ready, c < 16);
      tick();
    end
    for (int c = 0; c < 16; c++) begin
      drive(0, 0, 24'h0, 0, 0, 24'h0, 1, 1, 96'(c));
      #4;
      chk1($sformatf("post_rst_drain%0d_m0_valid", c), m0_rdata_valid, 1'b1);
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
